alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute/writeback stage sitting directly in front of the 2-read/1-write register file (`rf_2r1w`). It accepts decoded instructions over a valid/ready handshake and drives both RF read-address ports. It captures the returned operands with full bypassing from its own in-flight results, computes a 32-bit ALU result, and drives the RF write port. An optional iterative multiplier makes the stage multi-cycle for MUL.

## Interface
- `XLEN`, 32, datapath width; must equal the RF data width.
- `AW`, 5, register address width (32 registers; x0 hardwired to zero).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: instruction valid.
- `o_ready` out 1: stage can accept an instruction this cycle.
- `i_op` in 4: operation code (see Operation).
- `i_rs1`, `i_rs2`, `i_rd` in AW: source and destination register indices.
- `i_imm` in XLEN: immediate operand.
- `i_use_imm` in 1: operand B = `i_imm` instead of rs2.
- `o_rd_addr_1port`, `o_rd_addr_2port` out AW: to the RF read ports; combinationally equal to `i_rs1`/`i_rs2`.
- `i_rd_data_1port`, `i_rd_data_2port` in XLEN: RF combinational read data.
- `o_wr_addr` out AW, `o_wr_data` out XLEN, `o_wr_en` out 1: to the RF write port.
- `o_retired` out 32: count of instructions that reached WB; wraps modulo 2^32.

## Operation
- Handshake: an instruction is accepted on a rising edge where `i_valid && o_ready`. There is no backpressure from the RF.
- Pipeline: accept (cycle N, RF read) -> EX (N+1, ALU) -> WB (N+2, `o_wr_en` high, RF write at the end of N+2).
- Operand bypass, applied at capture, highest priority first:
  - EX stage combinational result, if EX valid, writing, and its rd matches the source.
  - WB register, same match rule.
  - RF read data otherwise.
  - Source index 0 always yields 0, overriding every bypass.
- Ops, all modulo 2^XLEN:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; the shift amount is B[log2(XLEN)-1:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1.
  - 10 MUL: low XLEN bits of the product; available only with the macro.
- Undefined op codes retire (count in `o_retired`) with `o_wr_en`=0.
- rd = 0: retires with `o_wr_en`=0 and is never a bypass source.
- EX FSM:
  - `IDLE` -> `MUL` when EX receives a MUL.
  - `MUL` runs XLEN cycles (one shift-add step per cycle), then returns to `IDLE` and loads WB.
- `o_ready` = (state == `IDLE`).
- Reset values: `o_wr_en` 0, `o_wr_addr` 0, `o_wr_data` 0, `o_retired` 0, EX/WB valid bits 0, state `IDLE` (so `o_ready` = 1).
- Reset mid-operation: all in-flight instructions are discarded and no RF write occurs.

## Timing
- Single-cycle op accepted at edge ending cycle N: `o_wr_en`=1 during N+2; RF holds the value after N+2.
- Back-to-back dependents in N and N+1 get the EX bypass. Dependents in N and N+2 get the WB bypass. Dependents in N and N+3 read the RF.
- MUL accepted in cycle N:
  - EX occupies N+1..N+XLEN; `o_ready`=0 throughout.
  - WB in N+XLEN+1, with `o_ready`=1 again in that cycle.
  - An instruction accepted in N+XLEN+1 gets the WB bypass of the product.
- `o_retired` increments at the edge ending each WB cycle. It shows value+1 from the next cycle.
- Only the RF address outputs are combinational from inputs.

## Configuration
- `ALU_EXEC_MUL_EN` defined: op 10 is an iterative multiply; the FSM and multiplier are present.
- `ALU_EXEC_MUL_EN` undefined: op 10 is undefined (retires, no write), the FSM is removed, and `o_ready` is constant 1.

## Structure
- Package `alu_exec_pkg`: `XLEN`/`AW` defaults, the op-code enum `alu_op_t`, and the FSM state enum.
- Sub-module `alu_exec_mul`: iterative shift-add multiplier (start, operands, busy, done, product). It is instantiated only under `ALU_EXEC_MUL_EN`.

## Test plan
- Reset: hold `rst_n`=0 -> `o_wr_en`=0, `o_wr_addr`=0, `o_retired`=0, `o_ready`=1; release -> no write until the first accept.
- Bypass chain:
  - Stimulus: RF x1=5; accept ADD x2=x1+imm 10 in N, then ADD x3=x2+x2 in N+1, then SUB x4=x3-x1 in N+3.
  - Response: writes x2=15 (N+2), x3=30 (N+3), x4=25 (N+5).
- x0 rules: ADD x0=x1+imm 7, then ADD x5=x0+imm 0 next cycle -> no write for x0; x5=0.
- Arithmetic corners:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
  - Undefined op 15 -> no write, `o_retired` +1.
- MUL with macro: MUL x6=7*6 accepted in N -> `o_ready` 0 for 32 cycles; write 42 in N+33. Without macro: no write.
- Reset mid-MUL: assert `rst_n` at N+10 -> no write ever; `o_ready`=1 after release; `o_retired` unchanged from 0.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared widths, op codes and EX state encoding for alu_exec_stage
package alu_exec_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/alu_exec_mul.sv
// rtl/alu_exec_mul.sv - iterative shift-add multiplier, one partial product per cycle (used under ALU_EXEC_MUL_EN)
module alu_exec_mul
    import alu_exec_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_step;

    // The last step's sum is presented directly so the product is usable in the done cycle.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CW'(XLEN - 1));
    assign product_o = acc_step;
    assign busy_o    = busy_q;

    // Load operands on start, then add-and-shift once per cycle for XLEN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute/writeback stage with operand bypass; ALU_EXEC_MUL_EN adds iterative MUL
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_op,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    input  logic [AW-1:0]   i_rd,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_use_imm,
    output logic [AW-1:0]   o_rd_addr_1port,
    output logic [AW-1:0]   o_rd_addr_2port,
    input  logic [XLEN-1:0] i_rd_data_1port,
    input  logic [XLEN-1:0] i_rd_data_2port,
    output logic [AW-1:0]   o_wr_addr,
    output logic [XLEN-1:0] o_wr_data,
    output logic            o_wr_en,
    output logic [31:0]     o_retired
);

    localparam int SW = $clog2(XLEN);

    logic            accept;
    logic            ex_valid_q;
    alu_op_t         ex_op_q;
    logic [AW-1:0]   ex_rd_q;
    logic [XLEN-1:0] ex_a_q;
    logic [XLEN-1:0] ex_b_q;
    logic [XLEN-1:0] ex_res;
    logic            ex_def;
    logic            ex_fwd;
    logic            ex_single;
    logic            ex_hold;
    logic            wb_valid_q;
    logic            wb_we_q;
    logic [AW-1:0]   wb_addr_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_fwd;
    logic [31:0]     retired_q;
    logic [XLEN-1:0] op_a_d;
    logic [XLEN-1:0] op_b_d;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign o_rd_addr_1port = i_rs1;
    assign o_rd_addr_2port = i_rs2;
    assign accept          = i_valid && o_ready;

    assign o_wr_en   = wb_valid_q && wb_we_q;
    assign o_wr_addr = wb_addr_q;
    assign o_wr_data = wb_data_q;
    assign o_retired = retired_q;

    // Single-cycle ALU on the captured operands; unknown codes (and MUL) flag ex_def low.
    always_comb begin
        ex_res = '0;
        ex_def = 1'b1;
        case (ex_op_q)
            OP_ADD:  ex_res = ex_a_q + ex_b_q;
            OP_SUB:  ex_res = ex_a_q - ex_b_q;
            OP_AND:  ex_res = ex_a_q & ex_b_q;
            OP_OR:   ex_res = ex_a_q | ex_b_q;
            OP_XOR:  ex_res = ex_a_q ^ ex_b_q;
            OP_SLL:  ex_res = ex_a_q << ex_b_q[SW-1:0];
            OP_SRL:  ex_res = ex_a_q >> ex_b_q[SW-1:0];
            OP_SRA:  ex_res = $signed(ex_a_q) >>> ex_b_q[SW-1:0];
            OP_SLT:  ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
            OP_SLTU: ex_res = {{(XLEN-1){1'b0}}, (ex_a_q < ex_b_q)};
            default: ex_def = 1'b0;
        endcase
    end

    // A MUL in EX has no result yet, so it never forwards from EX (ex_def is low for it).
    assign ex_fwd = ex_valid_q && ex_def && (ex_rd_q != '0);
    assign wb_fwd = wb_valid_q && wb_we_q;

    function automatic logic [XLEN-1:0] fwd_operand(input logic [AW-1:0]   src,
                                                    input logic [XLEN-1:0] rf_val);
        if (src == '0) return '0;
        if (ex_fwd && (ex_rd_q == src)) return ex_res;
        if (wb_fwd && (wb_addr_q == src)) return wb_data_q;
        return rf_val;
    endfunction

    assign op_a_d = fwd_operand(i_rs1, i_rd_data_1port);
    assign op_b_d = i_use_imm ? i_imm : fwd_operand(i_rs2, i_rd_data_2port);

`ifdef ALU_EXEC_MUL_EN
    ex_state_t state_q;
    logic      mul_start;
    logic      mul_busy;

    assign mul_start = accept && (i_op == OP_MUL);
    assign o_ready   = (state_q == ST_IDLE);
    assign ex_single = ex_valid_q && (ex_op_q != OP_MUL);
    assign ex_hold   = mul_busy && !mul_done;

    alu_exec_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (op_a_d),
        .b_i       (op_b_d),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // EX state: stall intake from MUL accept until the multiplier's final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_start) state_q <= ST_MUL;
                ST_MUL:  if (mul_done)  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_ready   = 1'b1;
    assign ex_single = ex_valid_q;
    assign ex_hold   = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`endif

    // Pipeline registers: capture at accept, EX to WB, retire counter on every WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= OP_ADD;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
        end else begin
            ex_valid_q <= accept || ex_hold;
            if (accept) begin
                ex_op_q <= alu_op_t'(i_op);
                ex_rd_q <= i_rd;
                ex_a_q  <= op_a_d;
                ex_b_q  <= op_b_d;
            end
            wb_valid_q <= ex_single || mul_done;
            if (mul_done) begin
                wb_we_q   <= (ex_rd_q != '0);
                wb_addr_q <= ex_rd_q;
                wb_data_q <= mul_prod;
            end else if (ex_single) begin
                wb_we_q   <= ex_def && (ex_rd_q != '0);
                wb_addr_q <= ex_rd_q;
                wb_data_q <= ex_res;
            end
            if (wb_valid_q) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage with a behavioural 2r1w register file
module tb_alu_exec_stage;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
    localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
    localparam logic [3:0] MUL = 4'd10, UNDEF = 4'd15;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [31:0] i_imm;
    logic        i_use_imm;
    logic [4:0]  o_rd_addr_1port, o_rd_addr_2port;
    logic [31:0] i_rd_data_1port, i_rd_data_2port;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_wr_en;
    logic [31:0] o_retired;

    logic [31:0] rf [32];
    int unsigned cyc = 0;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret = 0;

    alu_exec_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_op            (i_op),
        .i_rs1           (i_rs1),
        .i_rs2           (i_rs2),
        .i_rd            (i_rd),
        .i_imm           (i_imm),
        .i_use_imm       (i_use_imm),
        .o_rd_addr_1port (o_rd_addr_1port),
        .o_rd_addr_2port (o_rd_addr_2port),
        .i_rd_data_1port (i_rd_data_1port),
        .i_rd_data_2port (i_rd_data_2port),
        .o_wr_addr       (o_wr_addr),
        .o_wr_data       (o_wr_data),
        .o_wr_en         (o_wr_en),
        .o_retired       (o_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (o_wr_en && o_wr_addr != 5'd0) rf[o_wr_addr] <= o_wr_data;

    assign i_rd_data_1port = (o_rd_addr_1port == 5'd0) ? 32'd0 : rf[o_rd_addr_1port];
    assign i_rd_data_2port = (o_rd_addr_2port == 5'd0) ? 32'd0 : rf[o_rd_addr_2port];

    always @(negedge clk) if (o_wr_en) obs_q.push_back('{o_wr_addr, o_wr_data, cyc});

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic ui,
                         output int unsigned acc);
        i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_use_imm = ui;
        i_valid = 1'b1;
        acc = cyc;
        exp_ret = exp_ret + 1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int unsigned c);
        exp_q.push_back('{a, d, c});
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_valid = 1'b0; i_op = ADD; i_rd = 0; i_imm = 0; i_use_imm = 0;
        i_rs1 = 5'd3; i_rs2 = 5'd7;
        repeat (3) @(negedge clk);
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset wr_en: got %b, expected 0", o_wr_en); end
        n_checks++; if (o_wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset wr_addr: got %0d, expected 0", o_wr_addr); end
        n_checks++; if (o_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset wr_data: got 0x%08h, expected 0", o_wr_data); end
        n_checks++; if (o_retired !== 32'd0) begin n_fail++; $display("FAIL reset retired: got %0d, expected 0", o_retired); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b, expected 1", o_ready); end
        n_checks++; if (o_rd_addr_1port !== 5'd3 || o_rd_addr_2port !== 5'd7) begin
            n_fail++; $display("FAIL rd_addr ports: got %0d/%0d, expected 3/7", o_rd_addr_1port, o_rd_addr_2port); end
        rst_n = 1'b1;
        idle(4);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset release writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_bypass;
        int unsigned a, n, m, p;
        wr_t e, o;
        issue(ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, a); expect_wr(5'd1, 32'd5, a + 2);
        idle(3);
        issue(ADD, 5'd2, 5'd1, 5'd0, 32'd10, 1'b1, n); expect_wr(5'd2, 32'd15, n + 2);
        issue(ADD, 5'd3, 5'd2, 5'd2, 32'd0, 1'b0, a);  expect_wr(5'd3, 32'd30, n + 3);
        idle(1);
        issue(SUB, 5'd4, 5'd3, 5'd1, 32'd0, 1'b0, a);  expect_wr(5'd4, 32'd25, n + 5);
        issue(ADD, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1, m);  expect_wr(5'd7, 32'd1, m + 2);
        issue(ADD, 5'd7, 5'd0, 5'd0, 32'd2, 1'b1, a);  expect_wr(5'd7, 32'd2, m + 3);
        issue(ADD, 5'd8, 5'd7, 5'd0, 32'd0, 1'b0, a);  expect_wr(5'd8, 32'd2, m + 4);
        issue(ADD, 5'd28, 5'd0, 5'd0, 32'h55, 1'b1, p); expect_wr(5'd28, 32'h55, p + 2);
        idle(2);
        issue(ADD, 5'd29, 5'd28, 5'd0, 32'd1, 1'b1, a); expect_wr(5'd29, 32'h56, p + 5);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL bypass write: got none, expected x%0d=0x%08h @%0d", e.addr, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL bypass write: got x%0d=0x%08h @%0d, expected x%0d=0x%08h @%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bypass extra writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_x0;
        int unsigned a, n;
        wr_t e, o;
        issue(ADD, 5'd0, 5'd1, 5'd0, 32'd7, 1'b1, a);
        issue(ADD, 5'd5, 5'd0, 5'd0, 32'd0, 1'b1, n); expect_wr(5'd5, 32'd0, n + 2);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL x0 write: got none, expected x%0d=0x%08h @%0d", e.addr, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL x0 write: got x%0d=0x%08h @%0d, expected x%0d=0x%08h @%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL x0 extra writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL x0 retired: got %0d, expected %0d", o_retired, exp_ret); end
    endtask

    task automatic test_arith;
        int unsigned a;
        wr_t e, o;
        issue(ADD,  5'd9,  5'd0,  5'd0,  32'h8000_0000, 1'b1, a); expect_wr(5'd9,  32'h8000_0000, a + 2);
        issue(SRA,  5'd10, 5'd9,  5'd0,  32'd4,         1'b1, a); expect_wr(5'd10, 32'hF800_0000, a + 2);
        issue(SRL,  5'd20, 5'd9,  5'd0,  32'd4,         1'b1, a); expect_wr(5'd20, 32'h0800_0000, a + 2);
        issue(SUB,  5'd11, 5'd0,  5'd0,  32'd1,         1'b1, a); expect_wr(5'd11, 32'hFFFF_FFFF, a + 2);
        issue(ADD,  5'd12, 5'd0,  5'd0,  32'd1,         1'b1, a); expect_wr(5'd12, 32'd1,         a + 2);
        issue(SLTU, 5'd13, 5'd12, 5'd0,  32'hFFFF_FFFF, 1'b1, a); expect_wr(5'd13, 32'd1,         a + 2);
        issue(SLT,  5'd14, 5'd12, 5'd0,  32'hFFFF_FFFF, 1'b1, a); expect_wr(5'd14, 32'd0,         a + 2);
        issue(XOR_, 5'd15, 5'd11, 5'd0,  32'h0F0F_0F0F, 1'b1, a); expect_wr(5'd15, 32'hF0F0_F0F0, a + 2);
        issue(AND_, 5'd16, 5'd11, 5'd0,  32'h0000_1234, 1'b1, a); expect_wr(5'd16, 32'h0000_1234, a + 2);
        issue(OR_,  5'd17, 5'd9,  5'd0,  32'd1,         1'b1, a); expect_wr(5'd17, 32'h8000_0001, a + 2);
        issue(SLL,  5'd18, 5'd12, 5'd0,  32'd31,        1'b1, a); expect_wr(5'd18, 32'h8000_0000, a + 2);
        issue(SLL,  5'd19, 5'd12, 5'd0,  32'd33,        1'b1, a); expect_wr(5'd19, 32'd2,         a + 2);
        issue(SLT,  5'd21, 5'd11, 5'd12, 32'd0,         1'b0, a); expect_wr(5'd21, 32'd1,         a + 2);
        issue(UNDEF, 5'd3, 5'd1,  5'd1,  32'd0,         1'b0, a);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL arith write: got none, expected x%0d=0x%08h @%0d", e.addr, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL arith write: got x%0d=0x%08h @%0d, expected x%0d=0x%08h @%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL arith extra writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL arith retired: got %0d, expected %0d", o_retired, exp_ret); end
    endtask

    task automatic test_mul;
        int unsigned a, n;
        int busy;
        wr_t e, o;
        issue(ADD, 5'd22, 5'd0, 5'd0, 32'd7, 1'b1, a); expect_wr(5'd22, 32'd7, a + 2);
        issue(ADD, 5'd23, 5'd0, 5'd0, 32'd6, 1'b1, a); expect_wr(5'd23, 32'd6, a + 2);
        issue(MUL, 5'd6, 5'd22, 5'd23, 32'd0, 1'b0, n);
`ifdef ALU_EXEC_MUL_EN
        expect_wr(5'd6, 32'd42, n + 33);
        busy = 0;
        while (!o_ready && busy < 100) begin busy++; @(negedge clk); end
        n_checks++; if (busy != 32) begin n_fail++; $display("FAIL mul ready-low cycles: got %0d, expected 32", busy); end
        issue(ADD, 5'd24, 5'd6, 5'd0, 32'd0, 1'b1, a); expect_wr(5'd24, 32'd42, n + 35);
`else
        busy = o_ready ? 0 : 1;
        n_checks++; if (busy != 0) begin n_fail++; $display("FAIL mul ready: got %b, expected 1", o_ready); end
`endif
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL mul write: got none, expected x%0d=0x%08h @%0d", e.addr, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL mul write: got x%0d=0x%08h @%0d, expected x%0d=0x%08h @%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mul extra writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL mul retired: got %0d, expected %0d", o_retired, exp_ret); end
    endtask

    task automatic test_reset_midflight;
        int unsigned a;
        wr_t e, o;
        issue(ADD, 5'd26, 5'd0, 5'd0, 32'd9, 1'b1, a);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        exp_ret = 0;
        issue(MUL, 5'd25, 5'd22, 5'd23, 32'd0, 1'b0, a);
        idle(9);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        exp_ret = 0;
        idle(40);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset-midflight writes: got %0d, expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset-midflight ready: got %b, expected 1", o_ready); end
        n_checks++; if (o_retired !== 32'd0) begin n_fail++; $display("FAIL reset-midflight retired: got %0d, expected 0", o_retired); end
        issue(ADD, 5'd27, 5'd1, 5'd0, 32'd1, 1'b1, a); expect_wr(5'd27, 32'd6, a + 2);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL restart write: got none, expected x%0d=0x%08h @%0d", e.addr, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL restart write: got x%0d=0x%08h @%0d, expected x%0d=0x%08h @%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
            end
        end
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL restart retired: got %0d, expected %0d", o_retired, exp_ret); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset;
        test_bypass;
        test_x0;
        test_arith;
        test_mul;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
